// File: rtl/tt_cpu_gen.sv
`default_nettype none
// ============================================================================
// Module   : tt_cpu_gen
// Purpose  : Parametrised accumulator/register CPU for Tiny Tapeout tiles.
//            Four DATA_W-bit registers, Z/C flags, an 8-bit instruction
//            memory of MEM_DEPTH entries with an external load port, and an
//            IDLE/RUN/HALT control FSM. One instruction retires per clock in
//            RUN. Relative jumps wrap modulo MEM_DEPTH.
// Ports    : clk        clock, all state changes on the rising edge
//            rst        synchronous reset, active-high (memory is kept)
//            prog_we    program write strobe, honoured in IDLE/HALT only
//            prog_addr  program write address (PC_W bits)
//            prog_data  program write data (8 bits)
//            start      pulse: enter RUN at PC=0 (ignored while running)
//            step       (SINGLE_STEP_EN only) execute one instruction
//                       while halted; start wins when both are high
//            halted     high in IDLE and HALT
//            pc         current program counter
//            o_REG      value of register OUT_REG
// Options  : `define SINGLE_STEP_EN adds the step input.
// Revision : 1.0 - initial release
// ============================================================================
module tt_cpu_gen #(
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int PC_W      = $clog2(MEM_DEPTH),
    parameter int OUT_REG   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [7:0]        prog_data,
    input  logic              start,
`ifdef SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic              halted,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] o_REG
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_HALT = 2'd2;

    localparam logic [3:0] c_OP_JREL = 4'b0001;
    localparam logic [3:0] c_OP_JZ   = 4'b0010;
    localparam logic [3:0] c_OP_MOVL = 4'b0011;
    localparam logic [3:0] c_OP_MOVH = 4'b0100;
    localparam logic [3:0] c_OP_MOV  = 4'b0101;
    localparam logic [3:0] c_OP_ADD  = 4'b0110;
    localparam logic [3:0] c_OP_SUB  = 4'b0111;
    localparam logic [3:0] c_OP_SHL  = 4'b1000;
    localparam logic [3:0] c_OP_SHR  = 4'b1001;
    localparam logic [3:0] c_OP_SHN  = 4'b1010;
    localparam logic [3:0] c_OP_JC   = 4'b1011;
    localparam logic [3:0] c_OP_HALT = 4'b1111;

    localparam logic [1:0]      c_OUT_IDX = 2'(OUT_REG);
    localparam logic [PC_W-1:0] c_PC_ONE  = PC_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [PC_W-1:0]   r_pc;
    logic [DATA_W-1:0] r_regs [4];
    logic              r_z;
    logic              r_c;
    logic [7:0]        r_mem [MEM_DEPTH];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [7:0]        w_instr;
    logic [3:0]        w_op;
    logic [3:0]        w_imm;
    logic [1:0]        w_rd;
    logic [1:0]        w_rs;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W:0]   w_add;
    logic [DATA_W:0]   w_sub;
    logic [PC_W-1:0]   w_rel;
    logic [PC_W-1:0]   w_pc_inc;
    logic [PC_W-1:0]   w_pc_jump;

    logic              w_idle_or_halt;
    logic              w_launch;
    logic              w_exec;
    logic              w_halt_op;

    logic [DATA_W-1:0] w_regs_exec [4];
    logic [DATA_W-1:0] w_res;
    logic [PC_W-1:0]   w_pc_exec;
    logic              w_z_exec;
    logic              w_c_exec;

    assign w_instr = r_mem[r_pc];
    assign w_op    = w_instr[3:0];
    assign w_imm   = w_instr[7:4];
    assign w_rd    = w_instr[7:6];
    assign w_rs    = w_instr[5:4];

    // Both operands come from pre-edge values, so rd==rs needs no special case.
    assign w_a     = r_regs[w_rd];
    assign w_b     = r_regs[w_rs];
    // The extra top bit is carry for ADD and borrow for SUB.
    assign w_add   = {1'b0, w_a} + {1'b0, w_b};
    assign w_sub   = {1'b0, w_a} - {1'b0, w_b};

    // Sign-extend the 4-bit offset to the full PC so jumps wrap the whole
    // memory instead of staying inside a 16-entry page.
    assign w_rel     = PC_W'($signed(w_imm));
    assign w_pc_inc  = r_pc + c_PC_ONE;
    assign w_pc_jump = r_pc + w_rel;

    assign w_idle_or_halt = (r_state == c_ST_IDLE) || (r_state == c_ST_HALT);
    assign w_launch       = w_idle_or_halt && start;

`ifdef SINGLE_STEP_EN
    // A step while halted retires one instruction without leaving the
    // halted state; start takes precedence.
    assign w_exec = (r_state == c_ST_RUN) || (w_idle_or_halt && step && !start);
`else
    assign w_exec = (r_state == c_ST_RUN);
`endif

    // ------------------------------------------------------------------
    // Program memory: asynchronous read, writes locked out while running
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && prog_we && w_idle_or_halt) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_HALT: begin
                if (start) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (w_halt_op) begin
                    w_state_nxt = c_ST_HALT;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        halted = (r_state != c_ST_RUN);
        pc     = r_pc;
        o_REG  = r_regs[c_OUT_IDX];
    end

    // ------------------------------------------------------------------
    // Execute: next architectural state for the instruction at PC
    // ------------------------------------------------------------------
    always_comb begin
        w_regs_exec = r_regs;
        w_z_exec    = r_z;
        w_c_exec    = r_c;
        w_pc_exec   = w_pc_inc;
        w_halt_op   = 1'b0;
        w_res       = '0;
        case (w_op)
            c_OP_JREL: w_pc_exec = w_pc_jump;
            c_OP_JZ:   if (r_z) w_pc_exec = w_pc_jump;
            c_OP_JC:   if (r_c) w_pc_exec = w_pc_jump;
            c_OP_MOVL: w_regs_exec[0][3:0] = w_imm;
            c_OP_MOVH: w_regs_exec[0][7:4] = w_imm;
            c_OP_SHN:  w_regs_exec[0] = {r_regs[0][DATA_W-5:0], w_imm};
            c_OP_MOV:  w_regs_exec[w_rd] = w_b;
            c_OP_ADD: begin
                w_regs_exec[w_rd] = w_add[DATA_W-1:0];
                w_c_exec          = w_add[DATA_W];
                w_z_exec          = (w_add[DATA_W-1:0] == '0);
            end
            c_OP_SUB: begin
                w_regs_exec[w_rd] = w_sub[DATA_W-1:0];
                w_c_exec          = w_sub[DATA_W];
                w_z_exec          = (w_sub[DATA_W-1:0] == '0);
            end
            // Shifts reuse the rd field as the shift amount.
            c_OP_SHL: begin
                w_res             = w_b << w_rd;
                w_regs_exec[w_rs] = w_res;
                w_z_exec          = (w_res == '0);
            end
            c_OP_SHR: begin
                w_res             = w_b >> w_rd;
                w_regs_exec[w_rs] = w_res;
                w_z_exec          = (w_res == '0);
            end
            c_OP_HALT: begin
                w_pc_exec = r_pc;
                w_halt_op = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= '0;
            r_z  <= 1'b0;
            r_c  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_launch) begin
            // Registers and flags carry over into a new run.
            r_pc <= '0;
        end else if (w_exec) begin
            r_pc   <= w_pc_exec;
            r_z    <= w_z_exec;
            r_c    <= w_c_exec;
            r_regs <= w_regs_exec;
        end
    end

endmodule
`default_nettype wire

// File: doc/tt_cpu_gen.md
Name: tt_cpu_gen

Overview:
Parametrised next-generation accumulator/register CPU for Tiny Tapeout workshop tiles. Width, program depth and the observed register are configurable. Adds the following over the previous fixed 8-bit core:
- synchronous reset
- an external program-load port
- an IDLE/RUN/HALT state machine
- zero/carry flags with conditional relative branches
- full-PC relative jumps that wrap modulo program depth

Sits at the tile top; the observed register drives the output pins.

Parameters:
DATA_W, 8, register/data width; multiple of 4, >= 8
MEM_DEPTH, 256, program memory entries (8-bit instructions); power of 2, 16..256
PC_W, $clog2(MEM_DEPTH), program counter width (derived, do not override)
OUT_REG, 3, register index 0..3 driven onto o_REG

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
prog_we  input  1  program write strobe; honoured only in IDLE or HALT
prog_addr  input  PC_W  program write address
prog_data  input  8  program write data
start  input  1  one-cycle pulse: begin execution at PC=0
halted  output  1  high in IDLE and HALT
pc  output  PC_W  current program counter
o_REG  output  DATA_W  value of register OUT_REG

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-RUN):
  - state=IDLE, PC=0, r0..r3=0, Z=0, C=0
  - outputs: halted=1, pc=0, o_REG=0
  - program memory is NOT cleared.
- Memory and writes:
  - Memory has an asynchronous read, instr=MEM[PC].
  - Writes land at the edge when prog_we=1 and state is IDLE or HALT.
  - prog_we in RUN is ignored, with no side effects.
- State machine:
  - IDLE/HALT --start--> RUN. Entering RUN sets PC=0; registers and flags are kept.
  - start while in RUN is ignored.
  - rst has priority over start and prog_we.
- RUN execution:
  - One instruction per cycle, zero latency: result visible the cycle after the edge.
  - Field decode: op=instr[3:0], imm=instr[7:4], rd=instr[7:6], rs=instr[5:4].
  - Default next PC = PC+1, wrapping modulo MEM_DEPTH.
- Opcodes:
  - 0000 NOP.
  - 0001 JREL: PC <= PC + sext(imm), computed in PC_W bits (wraps; not page-limited).
  - 0010 JZ: JREL if Z=1, else PC+1.
  - 1011 JC: JREL if C=1, else PC+1.
  - 0011 MOVL: r0[3:0] <= imm.
  - 0100 MOVH: r0[7:4] <= imm.
  - 1010 SHN: r0 <= {r0[DATA_W-5:0], imm}, nibble shift-in used to build wide constants.
  - 0101 MOV: r[rd] <= r[rs].
  - 0110 ADD: r[rd] <= r[rd]+r[rs]; C = carry out of bit DATA_W-1.
  - 0111 SUB: r[rd] <= r[rd]-r[rs]; C = borrow (1 when r[rd] < r[rs], unsigned).
  - 1000 SHL: r[rs] <= r[rs] << rd (0..3); shift amount comes from instr[7:6].
  - 1001 SHR: r[rs] <= r[rs] >> rd, logical.
  - 1111 HALT: state <= HALT; PC holds at the HALT address.
  - All other opcodes execute as NOP.
- Flags:
  - Z <= (result==0) on ADD, SUB, SHL, SHR.
  - C updated only by ADD and SUB.
  - All other opcodes leave both flags unchanged.
- Same-register operands: rd==rs is legal and uses pre-edge values, e.g. ADD r1,r1 doubles r1; SUB r1,r1 gives 0, Z=1, C=0.
- Outside RUN: PC, registers and flags hold.

Optional Feature:
SINGLE_STEP_EN
- Defined:
  - Adds input port step (1 bit).
  - In HALT or IDLE, a step pulse executes exactly the instruction at the current PC, then remains halted.
  - If that instruction is HALT, it is a no-op: PC is unchanged.
  - step and start together: start wins.
  - In IDLE, the first step executes from PC=0.
- Undefined: no step port; core runs only through start.

Test Plan:
- Load {0x53 MOVL 5, 0x04 MOVH 0, 0xC5 MOV r3<-r0, 0x0F HALT}, pulse start -> halted=0 for 4 cycles, then halted=1, pc=3, o_REG=0x05.
- Program r0=0xFF via 0xF3,0xF4; MOV r1<-r0 (0x45); r0=0x01 (0x13,0x04); ADD r1+=r0 (0x46); JZ +2 (0x22) -> r1=0x00, Z=1, C=1, branch taken, instruction at JZ+1 skipped.
- MEM_DEPTH=256: place JREL +3 (0x31) at 0xFE -> next pc=0x01 (wrap). JREL -1 (0xF1) at 0x00 -> pc=0xFF.
- DATA_W=16: SHN 0xA, 0xB, 0xC, 0xD (0xAA,0xBA,0xCA,0xDA), MOV r3<-r0 -> o_REG=0xABCD.
- Mid-run rst after 2 instructions -> next cycle pc=0, o_REG=0, halted=1. Program memory intact; rerun gives identical result.
- prog_we to address 0 with 0x0F during RUN -> ignored, program result unchanged. The same write in HALT then start -> halts immediately at pc=0.
